hazard_forward_unit: RTL and testbench
======================================

# hazard_forward_unit

Parametrised successor to the decode-stage hazard detector. Tracks the register usage of the last FWD_DEPTH in-flight instructions and produces per-operand forwarding selects and load-use stall controls for the decode stage. Adds valid tracking, x0 exclusion, write-enable qualification, youngest-producer priority, configurable load latency, bubble insertion on stall, flush handling and an optional stall-cycle counter.

## Interface
- REGISTER_SIZE, 5, register index width
- FWD_DEPTH, 3, number of older in-flight instructions tracked (entry 1 = execute, entry 2 = memory, …); must be ≥ LOAD_LATENCY+1
- LOAD_LATENCY, 1, number of stages after execute before load data is forwardable
- SEL_W, $clog2(FWD_DEPTH+1), derived; width of stage selects

- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-low
- instr_valid  in  1  decode holds a real instruction
- destination_reg  in  REGISTER_SIZE  decode destination
- source_reg1  in  REGISTER_SIZE  decode operand A
- source_reg2  in  REGISTER_SIZE  decode operand B
- uses_src1, uses_src2  in  1 each  operand actually read
- reg_write  in  1  decode instruction writes destination
- dm_read_enable  in  1  decode instruction is a load
- flush  in  1  decode instruction is wrong-path
- f_to_d_enable_ff  out  1  fetch→decode flop enable
- d_to_e_enable_ff  out  1  decode→execute flop enable
- d_to_e_bubble  out  1  load NOP into execute this cycle
- fwd_stage_a, fwd_stage_b  out  SEL_W  0 = register file, k = entry k
- fwd_dm_a, fwd_dm_b  out  1  1 = take DM read data of that stage, 0 = ALU result
- stall_count  out  16  stall cycle count

## Operation
- History: entries 1..FWD_DEPTH, each {valid, dest, is_load}. Entry stored valid only if instr_valid & reg_write & dest≠0 & !flush & !stall.
- Per operand X (A/B), comb: candidates i where entry i valid, dest == srcX, uses_srcX, srcX≠0. Smallest i (youngest) wins; older matches ignored.
- Winner non-load: fwd_stage_X=i, fwd_dm_X=0.
- Winner load, i > LOAD_LATENCY: fwd_stage_X=i, fwd_dm_X=1.
- Winner load, i ≤ LOAD_LATENCY: load-use hazard → stall.
- No winner: fwd_stage_X=0, fwd_dm_X=0.
- stall = (hazard on A or B) & instr_valid & !flush. stall: f_to_d_enable_ff=0, d_to_e_enable_ff=0, d_to_e_bubble=1. Otherwise enables 1, bubble 0.
- Selects are driven whenever a winner exists, including during stall (don't-care to datapath).
- flush overrides stall: enables 1, bubble 1, invalid entry pushed.
- Entries past FWD_DEPTH are assumed retired; RF is write-before-read.

## Timing
- Selects and stall are combinational from inputs and history, same cycle.
- History shifts every cycle: entry i+1 ← entry i; entry 1 ← decode instruction, or invalid if stall/flush/!qualified. Oldest drops.
- Load at entry 1 with LOAD_LATENCY=1: exactly one stall cycle; next cycle load is entry 2 and forwards with fwd_dm=1. General: LOAD_LATENCY+1−i stall cycles for youngest load producer at entry i.
- Reset (rst=0 at edge): all entries invalid, stall_count=0. Outputs while history invalid: enables 1, bubble 0, selects 0, fwd_dm 0. Reset mid-stall releases the stall next cycle.
- Simultaneous A and B hazards: one stall; selects resolved independently.

## Configuration
- HAZARD_STALL_COUNT_EN defined: stall_count increments by 1 on each clock edge where stall=1, saturating at 16'hFFFF; cleared by reset only.
- Not defined: counter logic absent, stall_count tied to 16'h0000.

## Test plan
- After reset, add x3,x1,x2 then sub x4,x3,x5 → fwd_stage_a=1, fwd_dm_a=0, no stall; one NOP between → fwd_stage_a=2.
- lw x6 then add x7,x6,x6 (LOAD_LATENCY=1) → one cycle enables 0, bubble 1; next cycle fwd_stage_a=fwd_stage_b=2, fwd_dm=1; LOAD_LATENCY=2, FWD_DEPTH=4 → two stall cycles, then stage 3.
- add x8 at entry 2, addi x8 at entry 1, consumer reads x8 → fwd_stage_a=1 (youngest wins); same with lw x8 older, add x8 younger → no stall.
- Producer writes x0, or reg_write=0 (store/branch), or uses_src1=0 → fwd_stage 0, no stall.
- Load-use hazard with flush=1 → enables 1, bubble 1, no stall; following cycle entry 1 invalid.
- With HAZARD_STALL_COUNT_EN, three load-use stalls → stall_count=3; pulse rst=0 mid-stall → stall_count=0, enables 1 next cycle; without macro stall_count stays 0.

Source files
------------

// File: rtl/hazard_forward_unit.sv
// Decode-stage hazard detector: tracks the last FWD_DEPTH producers, picks forwarding stages and stalls on load-use.
// Optional feature: define HAZARD_STALL_COUNT_EN to enable the saturating stall cycle counter.
module hazard_forward_unit #(
  parameter int REGISTER_SIZE = 5,
  parameter int FWD_DEPTH     = 3,
  parameter int LOAD_LATENCY  = 1,
  parameter int SEL_W         = $clog2(FWD_DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     instr_valid,
  input  logic [REGISTER_SIZE-1:0] destination_reg,
  input  logic [REGISTER_SIZE-1:0] source_reg1,
  input  logic [REGISTER_SIZE-1:0] source_reg2,
  input  logic                     uses_src1,
  input  logic                     uses_src2,
  input  logic                     reg_write,
  input  logic                     dm_read_enable,
  input  logic                     flush,
  output logic                     f_to_d_enable_ff,
  output logic                     d_to_e_enable_ff,
  output logic                     d_to_e_bubble,
  output logic [SEL_W-1:0]         fwd_stage_a,
  output logic [SEL_W-1:0]         fwd_stage_b,
  output logic                     fwd_dm_a,
  output logic                     fwd_dm_b,
  output logic [15:0]              stall_count
);

  typedef struct packed {
    logic                     valid;
    logic [REGISTER_SIZE-1:0] dest;
    logic                     is_load;
  } entry_t;

  typedef struct packed {
    logic             hit;
    logic [SEL_W-1:0] sel;
    logic             is_load;
  } match_t;

  entry_t r_hist [1:FWD_DEPTH];

  match_t w_match_a;
  match_t w_match_b;
  logic   w_hazard_a;
  logic   w_hazard_b;
  logic   w_stall;
  entry_t w_push;

  // Scan oldest to youngest so the youngest matching producer overwrites older ones.
  function automatic match_t resolve(input logic [REGISTER_SIZE-1:0] src, input logic uses);
    match_t m;
    m = '0;
    for (int i = FWD_DEPTH; i >= 1; i--) begin
      if (uses && (src != '0) && r_hist[i].valid && (r_hist[i].dest == src)) begin
        m.hit     = 1'b1;
        m.sel     = SEL_W'(i);
        m.is_load = r_hist[i].is_load;
      end
    end
    return m;
  endfunction

  assign w_match_a  = resolve(source_reg1, uses_src1);
  assign w_match_b  = resolve(source_reg2, uses_src2);
  assign w_hazard_a = w_match_a.hit && w_match_a.is_load && (int'(w_match_a.sel) <= LOAD_LATENCY);
  assign w_hazard_b = w_match_b.hit && w_match_b.is_load && (int'(w_match_b.sel) <= LOAD_LATENCY);
  assign w_stall    = (w_hazard_a || w_hazard_b) && instr_valid && !flush;

  assign fwd_stage_a      = w_match_a.sel;
  assign fwd_stage_b      = w_match_b.sel;
  assign fwd_dm_a         = w_match_a.hit && w_match_a.is_load;
  assign fwd_dm_b         = w_match_b.hit && w_match_b.is_load;
  assign f_to_d_enable_ff = !w_stall;
  assign d_to_e_enable_ff = !w_stall;
  assign d_to_e_bubble    = w_stall || flush;

  assign w_push.valid   = instr_valid && reg_write && (destination_reg != '0) && !flush && !w_stall;
  assign w_push.dest    = destination_reg;
  assign w_push.is_load = dm_read_enable;

  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: only the valid bits need reset; dest/is_load are ignored while an entry is invalid.
      for (int i = 1; i <= FWD_DEPTH; i++) r_hist[i].valid <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every entry shift from its pre-edge neighbour.
      r_hist[1] <= w_push;
      for (int i = 2; i <= FWD_DEPTH; i++) r_hist[i] <= r_hist[i-1];
    end
  end

`ifdef HAZARD_STALL_COUNT_EN
  logic [15:0] r_stall_count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stall_count <= 16'h0000;
    end else if (w_stall && (r_stall_count != 16'hFFFF)) begin
      r_stall_count <= r_stall_count + 16'h0001;
    end
  end

  assign stall_count = r_stall_count;
`else
  assign stall_count = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench: one DUT at default parameters, a second with LOAD_LATENCY=2 / FWD_DEPTH=4 on the same inputs.
module tb_hazard_forward_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       instr_valid = 1'b0;
  logic [4:0] destination_reg = '0;
  logic [4:0] source_reg1 = '0;
  logic [4:0] source_reg2 = '0;
  logic       uses_src1 = 1'b0;
  logic       uses_src2 = 1'b0;
  logic       reg_write = 1'b0;
  logic       dm_read_enable = 1'b0;
  logic       flush = 1'b0;

  logic        f1, d1, b1, da1, db1;
  logic [1:0]  sa1, sb1;
  logic [15:0] cnt1;
  logic        f2, d2, b2, da2, db2;
  logic [2:0]  sa2, sb2;
  logic [15:0] cnt2;

  logic [8:0]  obs1;
  logic [10:0] obs2;
  logic [8:0]  e9;
  logic [10:0] e11;
  logic [6:0]  e7;
  logic [8:0]  es9;
  logic [15:0] exp_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  assign obs1 = {f1, d1, b1, sa1, da1, sb1, db1};
  assign obs2 = {f2, d2, b2, sa2, da2, sb2, db2};

  hazard_forward_unit dut1 (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .destination_reg(destination_reg),
    .source_reg1(source_reg1), .source_reg2(source_reg2), .uses_src1(uses_src1),
    .uses_src2(uses_src2), .reg_write(reg_write), .dm_read_enable(dm_read_enable),
    .flush(flush), .f_to_d_enable_ff(f1), .d_to_e_enable_ff(d1), .d_to_e_bubble(b1),
    .fwd_stage_a(sa1), .fwd_stage_b(sb1), .fwd_dm_a(da1), .fwd_dm_b(db1), .stall_count(cnt1)
  );

  hazard_forward_unit #(.FWD_DEPTH(4), .LOAD_LATENCY(2)) dut2 (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .destination_reg(destination_reg),
    .source_reg1(source_reg1), .source_reg2(source_reg2), .uses_src1(uses_src1),
    .uses_src2(uses_src2), .reg_write(reg_write), .dm_read_enable(dm_read_enable),
    .flush(flush), .f_to_d_enable_ff(f2), .d_to_e_enable_ff(d2), .d_to_e_bubble(b2),
    .fwd_stage_a(sa2), .fwd_stage_b(sb2), .fwd_dm_a(da2), .fwd_dm_b(db2), .stall_count(cnt2)
  );

  always #5 clk = ~clk;

  task automatic set_in(input logic v, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic u1, input logic u2,
                        input logic rw, input logic ld, input logic fl);
    instr_valid     = v;
    destination_reg = rd;
    source_reg1     = rs1;
    source_reg2     = rs2;
    uses_src1       = u1;
    uses_src2       = u2;
    reg_write       = rw;
    dm_read_enable  = ld;
    flush           = fl;
  endtask

  task automatic settle;
    @(negedge clk);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset;
    idle();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset;
    do_reset();
    settle();
    e9 = 9'b110_00_0_00_0;
    n_tests++; if (obs1 !== e9) begin n_fail++; $display("FAIL reset_outputs_d1 got=%b exp=%b", obs1, e9); end
    e11 = 11'b110_000_0_000_0;
    n_tests++; if (obs2 !== e11) begin n_fail++; $display("FAIL reset_outputs_d2 got=%b exp=%b", obs2, e11); end
    n_tests++; if (cnt1 !== 16'h0000) begin n_fail++; $display("FAIL reset_count got=%h exp=0000", cnt1); end
    tick();
  endtask

  task automatic test_alu_forward;
    do_reset();
    set_in(1'b1, 5'd3, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);  // add x3,x1,x2
    settle();
    e9 = 9'b110_00_0_00_0;
    n_tests++; if (obs1 !== e9) begin n_fail++; $display("FAIL alu_first got=%b exp=%b", obs1, e9); end
    tick();
    set_in(1'b1, 5'd4, 5'd3, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);  // sub x4,x3,x5
    settle();
    e9 = 9'b110_01_0_00_0;
    n_tests++; if (obs1 !== e9) begin n_fail++; $display("FAIL alu_fwd_entry1 got=%b exp=%b", obs1, e9); end
    tick();
    set_in(1'b1, 5'd10, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0); // add x10
    tick();
    idle();
    tick();
    set_in(1'b1, 5'd11, 5'd10, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    settle();
    e9 = 9'b110_10_0_00_0;
    n_tests++; if (obs1 !== e9) begin n_fail++; $display("FAIL alu_fwd_entry2 got=%b exp=%b", obs1, e9); end
    idle();
    tick();
    set_in(1'b1, 5'd0, 5'd10, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    settle();
    e9 = 9'b110_11_0_00_0;
    n_tests++; if (obs1 !== e9) begin n_fail++; $display("FAIL alu_fwd_entry3 got=%b exp=%b", obs1, e9); end
    idle();
    tick();
    set_in(1'b1, 5'd0, 5'd10, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    settle();
    e9 = 9'b110_00_0_00_0;
    n_tests++; if (obs1 !== e9) begin n_fail++; $display("FAIL alu_retired got=%b exp=%b", obs1, e9); end
    tick();
  endtask

  task automatic test_load_use;
    do_reset();
    set_in(1'b1, 5'd6, 5'd1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);  // lw x6
    tick();
    set_in(1'b1, 5'd7, 5'd6, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);  // add x7,x6,x6
    settle();
    e7 = 7'b001_01_01;
    n_tests++; if ({obs1[8:6], sa1, sb1} !== e7) begin n_fail++; $display("FAIL load_use_stall_d1 got=%b exp=%b", {obs1[8:6], sa1, sb1}, e7); end
    es9 = 9'b001_001_001;
    n_tests++; if ({obs2[10:8], sa2, sb2} !== es9) begin n_fail++; $display("FAIL load_use_stall1_d2 got=%b exp=%b", {obs2[10:8], sa2, sb2}, es9); end
    tick();
    settle();
    e9 = 9'b110_10_1_10_1;
    n_tests++; if (obs1 !== e9) begin n_fail++; $display("FAIL load_use_release_d1 got=%b exp=%b", obs1, e9); end
    es9 = 9'b001_010_010;
    n_tests++; if ({obs2[10:8], sa2, sb2} !== es9) begin n_fail++; $display("FAIL load_use_stall2_d2 got=%b exp=%b", {obs2[10:8], sa2, sb2}, es9); end
    tick();
    settle();
    e11 = 11'b110_011_1_011_1;
    n_tests++; if (obs2 !== e11) begin n_fail++; $display("FAIL load_use_release_d2 got=%b exp=%b", obs2, e11); end
    tick();
  endtask

  task automatic test_youngest;
    do_reset();
    set_in(1'b1, 5'd8, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);  // add x8
    tick();
    set_in(1'b1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);  // addi x8,x8
    tick();
    set_in(1'b1, 5'd9, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    settle();
    e9 = 9'b110_01_0_00_0;
    n_tests++; if (obs1 !== e9) begin n_fail++; $display("FAIL youngest_alu got=%b exp=%b", obs1, e9); end
    do_reset();
    set_in(1'b1, 5'd8, 5'd1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);  // lw x8
    tick();
    set_in(1'b1, 5'd8, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);  // add x8
    tick();
    set_in(1'b1, 5'd9, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    settle();
    e9 = 9'b110_01_0_00_0;
    n_tests++; if (obs1 !== e9) begin n_fail++; $display("FAIL youngest_over_load_d1 got=%b exp=%b", obs1, e9); end
    e11 = 11'b110_001_0_000_0;
    n_tests++; if (obs2 !== e11) begin n_fail++; $display("FAIL youngest_over_load_d2 got=%b exp=%b", obs2, e11); end
    tick();
  endtask

  task automatic test_qualify;
    do_reset();
    set_in(1'b1, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);  // add x0
    tick();
    set_in(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    settle();
    e9 = 9'b110_00_0_00_0;
    n_tests++; if (obs1 !== e9) begin n_fail++; $display("FAIL x0_excluded got=%b exp=%b", obs1, e9); end
    set_in(1'b1, 5'd12, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); // store-like, no write
    tick();
    set_in(1'b1, 5'd0, 5'd12, 5'd12, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    settle();
    n_tests++; if (obs1 !== e9) begin n_fail++; $display("FAIL no_reg_write got=%b exp=%b", obs1, e9); end
    set_in(1'b1, 5'd13, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0); // add x13
    tick();
    set_in(1'b1, 5'd0, 5'd13, 5'd13, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    settle();
    e9 = 9'b110_00_0_01_0;
    n_tests++; if (obs1 !== e9) begin n_fail++; $display("FAIL uses_src1_low got=%b exp=%b", obs1, e9); end
    do_reset();
    set_in(1'b1, 5'd15, 5'd1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0); // lw x15
    tick();
    set_in(1'b0, 5'd0, 5'd15, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    settle();
    e7 = 7'b110_01_00;
    n_tests++; if ({obs1[8:6], sa1, sb1} !== e7) begin n_fail++; $display("FAIL invalid_no_stall got=%b exp=%b", {obs1[8:6], sa1, sb1}, e7); end
    tick();
  endtask

  task automatic test_flush;
    do_reset();
    set_in(1'b1, 5'd6, 5'd1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);  // lw x6
    tick();
    set_in(1'b1, 5'd7, 5'd6, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);  // flushed add x7
    settle();
    n_tests++; if (obs1[8:6] !== 3'b111) begin n_fail++; $display("FAIL flush_ctrl got=%b exp=111", obs1[8:6]); end
    tick();
    set_in(1'b1, 5'd0, 5'd7, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    settle();
    e9 = 9'b110_00_0_10_1;
    n_tests++; if (obs1 !== e9) begin n_fail++; $display("FAIL flush_entry_invalid got=%b exp=%b", obs1, e9); end
    tick();
  endtask

  task automatic test_back_to_back;
    do_reset();
    set_in(1'b1, 5'd20, 5'd1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0); // lw x20
    tick();
    set_in(1'b1, 5'd21, 5'd1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0); // lw x21
    tick();
    set_in(1'b1, 5'd22, 5'd20, 5'd21, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    settle();
    e7 = 7'b001_10_01;
    n_tests++; if ({obs1[8:6], sa1, sb1} !== e7) begin n_fail++; $display("FAIL dual_stall_d1 got=%b exp=%b", {obs1[8:6], sa1, sb1}, e7); end
    es9 = 9'b001_010_001;
    n_tests++; if ({obs2[10:8], sa2, sb2} !== es9) begin n_fail++; $display("FAIL dual_stall1_d2 got=%b exp=%b", {obs2[10:8], sa2, sb2}, es9); end
    tick();
    settle();
    e9 = 9'b110_11_1_10_1;
    n_tests++; if (obs1 !== e9) begin n_fail++; $display("FAIL dual_release_d1 got=%b exp=%b", obs1, e9); end
    es9 = 9'b001_011_010;
    n_tests++; if ({obs2[10:8], sa2, sb2} !== es9) begin n_fail++; $display("FAIL dual_stall2_d2 got=%b exp=%b", {obs2[10:8], sa2, sb2}, es9); end
    tick();
    settle();
    e11 = 11'b110_100_1_011_1;
    n_tests++; if (obs2 !== e11) begin n_fail++; $display("FAIL dual_release_d2 got=%b exp=%b", obs2, e11); end
    tick();
  endtask

  task automatic test_stall_count;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      set_in(1'b1, 5'd6, 5'd1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      tick();
      set_in(1'b1, 5'd0, 5'd6, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      tick();
    end
    settle();
`ifdef HAZARD_STALL_COUNT_EN
    exp_cnt = 16'd3;
`else
    exp_cnt = 16'd0;
`endif
    n_tests++; if (cnt1 !== exp_cnt) begin n_fail++; $display("FAIL stall_count got=%0d exp=%0d", cnt1, exp_cnt); end
    tick();
    set_in(1'b1, 5'd6, 5'd1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    set_in(1'b1, 5'd0, 5'd6, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    settle();
    n_tests++; if (obs1[8:6] !== 3'b001) begin n_fail++; $display("FAIL mid_stall_pre got=%b exp=001", obs1[8:6]); end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    settle();
    n_tests++; if (obs1[8:6] !== 3'b110) begin n_fail++; $display("FAIL mid_stall_release got=%b exp=110", obs1[8:6]); end
    n_tests++; if (cnt1 !== 16'h0000) begin n_fail++; $display("FAIL count_cleared got=%h exp=0000", cnt1); end
    tick();
  endtask

  initial begin
    test_reset();
    test_alu_forward();
    test_load_use();
    test_youngest();
    test_qualify();
    test_flush();
    test_back_to_back();
    test_stall_count();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
